// File: rtl/sr_skew_bank.sv
// Shift-register bank that skews aligned lane vectors into a staircase, or deskews a staircase.
// Optional build macro SR_OUT_MASK_EN forces each out_data lane to zero while its o_vld is low.
module sr_skew_bank #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned BASE_DELAY = 1,
  parameter int unsigned DESKEW     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_en,
  input  logic                         i_flush,
  input  logic [CHANNELS-1:0]          i_vld,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  output logic [CHANNELS-1:0]          o_vld,
  output logic [CHANNELS*WIDTH-1:0]    out_data,
  output logic                         o_busy
);

  logic [CHANNELS-1:0] lane_busy;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    localparam int unsigned LaneDepth = (DESKEW != 0) ? BASE_DELAY + (CHANNELS - 1 - k)
                                                      : BASE_DELAY + k;

    // Stage 0 sits in the low slice; the last stage is the top slice.
    logic [LaneDepth*WIDTH-1:0] data_q, data_d;
    logic [LaneDepth-1:0]       vld_q, vld_d;
    logic [WIDTH-1:0]           last_data;

    if (LaneDepth == 1) begin : g_single
      assign data_d = in_data[k*WIDTH +: WIDTH];
      assign vld_d  = i_vld[k];
    end else begin : g_multi
      assign data_d = {data_q[(LaneDepth-1)*WIDTH-1:0], in_data[k*WIDTH +: WIDTH]};
      assign vld_d  = {vld_q[LaneDepth-2:0], i_vld[k]};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
        vld_q  <= '0;
      end else if (i_flush) begin
        // Data is left in place; only the beats are killed.
        vld_q  <= '0;
      end else if (i_en) begin
        data_q <= data_d;
        vld_q  <= vld_d;
      end
    end

    assign last_data    = data_q[LaneDepth*WIDTH-1 -: WIDTH];
    assign o_vld[k]     = vld_q[LaneDepth-1];
    assign lane_busy[k] = |vld_q;

`ifdef SR_OUT_MASK_EN
    assign out_data[k*WIDTH +: WIDTH] = vld_q[LaneDepth-1] ? last_data : '0;
`else
    assign out_data[k*WIDTH +: WIDTH] = last_data;
`endif
  end

  assign o_busy = |lane_busy;

endmodule

// File: tb/tb_sr_skew_bank.sv
// Directed self-checking bench for sr_skew_bank: one skew instance and one deskew instance.
module tb_sr_skew_bank;

  logic        clk = 1'b0;
  logic        rst, i_en, i_flush;
  logic [3:0]  i_vld, d_vld;
  logic [63:0] in_data, d_data;
  logic [3:0]  o_vld, d_o_vld;
  logic [63:0] out_data, d_out_data;
  logic        o_busy, d_o_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_skew_bank #(.WIDTH(16), .CHANNELS(4), .BASE_DELAY(1), .DESKEW(0)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_flush(i_flush), .i_vld(i_vld),
    .in_data(in_data), .o_vld(o_vld), .out_data(out_data), .o_busy(o_busy)
  );

  sr_skew_bank #(.WIDTH(16), .CHANNELS(4), .BASE_DELAY(1), .DESKEW(1)) dut_dsk (
    .clk(clk), .rst(rst), .i_en(i_en), .i_flush(i_flush), .i_vld(d_vld),
    .in_data(d_data), .o_vld(d_o_vld), .out_data(d_out_data), .o_busy(d_o_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lane(input logic [63:0] bus, input int k);
    return bus[k*16 +: 16];
  endfunction

  initial begin
    logic [3:0]  ev;
    logic [15:0] vals [4];
    rst = 1'b1; i_en = 1'b1; i_flush = 1'b0;
    i_vld = '0; in_data = '0; d_vld = '0; d_data = '0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk("rst_vld", {28'd0, o_vld}, 32'h0);
    chk("rst_data_lo", out_data[31:0], 32'h0);
    chk("rst_data_hi", out_data[63:32], 32'h0);
    chk("rst_busy", {31'd0, o_busy}, 32'h0);

    // Single aligned beat becomes a staircase
    vals = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
    i_vld = 4'hF;
    in_data = {vals[3], vals[2], vals[1], vals[0]};
    for (int s = 0; s < 6; s++) begin
      step();
      i_vld = '0; in_data = '0;
      ev = (s < 4) ? 4'(1 << s) : 4'h0;
      chk($sformatf("skew1_vld_s%0d", s), {28'd0, o_vld}, {28'd0, ev});
      chk($sformatf("skew1_busy_s%0d", s), {31'd0, o_busy}, {31'd0, (s < 4)});
      if (s < 4) chk($sformatf("skew1_data_s%0d", s), {16'd0, lane(out_data, s)},
                     {16'd0, vals[s]});
    end

    // Three back-to-back beats
    for (int s = 0; s < 7; s++) begin
      i_vld = (s < 3) ? 4'hF : 4'h0;
      in_data = (s < 3) ? {4{16'((s + 1) * 16'h1111)}} : 64'h0;
      step();
      for (int k = 0; k < 4; k++) begin
        ev[k] = (s >= k) && (s - k <= 2);
        if (ev[k]) chk($sformatf("b2b_data_s%0d_l%0d", s, k), {16'd0, lane(out_data, k)},
                       {16'd0, 16'((s - k + 1) * 16'h1111)});
      end
      chk($sformatf("b2b_vld_s%0d", s), {28'd0, o_vld}, {28'd0, ev});
    end

    // Stall for two cycles after sampling ABCD; beats offered during stall are dropped
    i_vld = 4'hF; in_data = {4{16'hABCD}};
    step();
    chk("stall_vld_e0", {28'd0, o_vld}, 32'h1);
    i_en = 1'b0; in_data = {4{16'hDEAD}};
    for (int s = 0; s < 2; s++) begin
      step();
      chk($sformatf("stall_hold_vld_%0d", s), {28'd0, o_vld}, 32'h1);
      chk($sformatf("stall_hold_data_%0d", s), {16'd0, lane(out_data, 0)}, 32'hABCD);
    end
    i_en = 1'b1; i_vld = '0; in_data = '0;
    for (int s = 1; s < 7; s++) begin
      step();
      ev = (s < 4) ? 4'(1 << s) : 4'h0;
      chk($sformatf("stall_vld_s%0d", s), {28'd0, o_vld}, {28'd0, ev});
      if (s < 4) chk($sformatf("stall_data_s%0d", s), {16'd0, lane(out_data, s)}, 32'hABCD);
    end
    chk("stall_busy_end", {31'd0, o_busy}, 32'h0);

    // Flush with two beats in flight and a beat offered on the flush edge
    i_vld = 4'hF; in_data = {4{16'h1111}};
    step();
    in_data = {4{16'h2222}};
    step();
    chk("flush_pre_vld", {28'd0, o_vld}, 32'h3);
    i_flush = 1'b1; in_data = {4{16'h1234}};
    step();
    i_flush = 1'b0; i_vld = '0; in_data = '0;
    chk("flush_vld", {28'd0, o_vld}, 32'h0);
    chk("flush_busy", {31'd0, o_busy}, 32'h0);
    for (int s = 0; s < 5; s++) begin
      step();
      chk($sformatf("flush_quiet_%0d", s), {27'd0, o_busy, o_vld}, 32'h0);
    end

    // Reset mid-flight
    i_vld = 4'hF; in_data = {4{16'h5A5A}};
    step();
    i_vld = '0; in_data = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_vld", {28'd0, o_vld}, 32'h0);
    chk("rstmid_busy", {31'd0, o_busy}, 32'h0);
    chk("rstmid_data_lo", out_data[31:0], 32'h0);
    chk("rstmid_data_hi", out_data[63:32], 32'h0);

    // Invalid beat data visibility depends on the output mask build
    i_vld = 4'h0; in_data = {4{16'h5555}};
    step();
    in_data = '0;
    chk("nv_vld", {28'd0, o_vld}, 32'h0);
`ifdef SR_OUT_MASK_EN
    chk("nv_data_masked", {16'd0, lane(out_data, 0)}, 32'h0);
`else
    chk("nv_data_raw", {16'd0, lane(out_data, 0)}, 32'h5555);
`endif

    // Deskew: staircase input yields one aligned output vector
    for (int s = 0; s < 5; s++) begin
      d_vld = (s < 4) ? 4'(1 << s) : 4'h0;
      d_data = '0;
      if (s < 4) d_data[s*16 +: 16] = 16'(16'h00C0 + s);
      step();
      ev = (s == 3) ? 4'hF : 4'h0;
      chk($sformatf("dsk_vld_s%0d", s), {28'd0, d_o_vld}, {28'd0, ev});
    end
    d_vld = '0; d_data = '0;
    // Outputs were aligned on the previous cycle; re-run to inspect the data directly.
    for (int s = 0; s < 4; s++) begin
      d_vld = 4'(1 << s);
      d_data = '0;
      d_data[s*16 +: 16] = 16'(16'h00C0 + s);
      step();
    end
    d_vld = '0; d_data = '0;
    for (int k = 0; k < 4; k++)
      chk($sformatf("dsk_data_l%0d", k), {16'd0, lane(d_out_data, k)}, 32'(16'h00C0 + k));
    chk("dsk_busy", {31'd0, d_o_busy}, 32'h1);
    step();
    chk("dsk_busy_end", {27'd0, d_o_busy, d_o_vld}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_skew_bank.md
# sr_skew_bank

Multi-channel parametrised shift-register bank with per-lane valid, used to skew operand vectors into a systolic array (row k delayed by k extra cycles) or to deskew its staggered results back into aligned vectors. Each lane is an independent delay line of WIDTH-bit data plus a valid bit. A global enable stalls all lanes, and a synchronous flush kills every in-flight beat. Sits between the operand buffers and the array edges, and between the array outputs and the result collector.

## Interface
- WIDTH, 16: data bits per lane
- CHANNELS, 4: number of lanes, ≥1
- BASE_DELAY, 1: minimum lane delay in enabled cycles, ≥1
- DESKEW, 0: 0 → lane k delay D_k = BASE_DELAY + k; 1 → D_k = BASE_DELAY + (CHANNELS-1-k)

- clk  in  1  single clock, all state on posedge
- rst  in  1  synchronous reset, active-high
- i_en  in  1  global shift enable; 0 = hold all stages
- i_flush  in  1  synchronous clear of all valid bits
- i_vld  in  CHANNELS  per-lane input valid
- in_data  in  CHANNELS*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
- o_vld  out  CHANNELS  per-lane output valid
- out_data  out  CHANNELS*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
- o_busy  out  1  OR of every valid bit in every stage of every lane

## Operation
- Lane k has D_k registered stages, each holding data and valid. o_vld[k] and out_data lane k are driven directly from the last stage, with no combinational path from inputs.
- Total stage count is CHANNELS*BASE_DELAY + CHANNELS*(CHANNELS-1)/2.
- Priority on each edge is rst > i_flush > i_en:
  - rst: all valid bits and data registers cleared to 0.
  - i_flush=1: all valid bits cleared and data registers untouched. Input beats presented on the same edge are dropped, regardless of i_en.
  - i_en=1: every stage takes its predecessor's data and valid. Stage 0 takes in_data/i_vld, and data is captured even when valid is 0.
  - i_en=0: all stages hold, and inputs are ignored (not buffered).
- Lanes are fully independent. Arbitrary i_vld patterns, including gaps and back-to-back beats, are preserved in order with no reordering or merging.
- Skew mode converts aligned input vectors into a staircase. Deskew mode with an input staircase (lane k valid k cycles after lane 0) produces aligned output vectors.
- o_busy is combinational from the stage valid bits only. It is 0 one cycle after rst or i_flush.

## Timing
- Reset values: o_vld=0, out_data=0, o_busy=0.
- Latency: a beat sampled on enabled edge E is on lane k's output after the D_k-th enabled edge counting E as the first. For D_k=1 it appears in the cycle right after E.
- Stall: each disabled cycle extends the latency of every in-flight beat by 1. Outputs hold stable, including o_vld, during the stall.
- Throughput: one beat per lane per enabled cycle.
- Each beat's o_vld pulse lasts exactly one enabled cycle, plus any intervening stall cycles.
- rst or i_flush mid-flight: all o_vld are 0 from the next cycle. No partial beats emerge afterwards.

## Configuration
- SR_OUT_MASK_EN
  - Defined: each out_data lane is forced to 0 whenever its o_vld bit is 0.
  - Undefined: out_data lanes always show the raw last-stage data register. Stale or invalid-beat data is visible while o_vld is 0.
- o_vld, o_busy and latency are identical in both builds.

## Test plan
All scenarios use CHANNELS=4, WIDTH=16, BASE_DELAY=1 unless noted.

- Skew, single aligned beat, i_vld=4'b1111, lanes {000A,000B,000C,000D}, one cycle, i_en=1 → lane k valid exactly in cycle k+1 after the sampling edge with its own value. o_busy is high for 4 cycles, then 0.
- Back-to-back: 3 aligned beats {0x1111,0x2222,0x3333} on all lanes → each lane shows 3 consecutive valids in order. Lane 3 starts 3 cycles after lane 0.
- Stall: i_en=0 for 2 cycles right after sampling 0xABCD on all lanes → outputs frozen during the stall. Lane k valid arrives at cycle k+3. Inputs offered during the stall never appear.
- Flush: i_flush=1 with 2 beats in flight and i_vld=4'b1111 (data 0x1234) on the same edge → all o_vld=0 and o_busy=0 next cycle. 0x1234 never emerges.
- Deskew (DESKEW=1): lane k fed 0x00C0+k with i_vld[k] at cycle k → all 4 lanes valid in the same cycle, 4 cycles after lane 0's sampling edge.
- Reset mid-flight, then the build variants:
  - rst with beats in flight → o_vld=0, o_busy=0, out_data=0 next cycle.
  - With SR_OUT_MASK_EN: out_data=0 on every cycle where o_vld=0.
  - Without SR_OUT_MASK_EN: last-stage data is visible while o_vld=0, e.g. data 0x5555 sent with i_vld=0 shows on lane 0 out_data with o_vld[0]=0.
